// File: rtl/kbd_buffer_pkg.sv
// -----------------------------------------------------------------------------
// kbd_buffer_pkg
//   Shared types and defaults for the keyboard type-ahead buffer.
//
//   kbd_mode_e   : KBD_FIFO   - queued type-ahead, one entry consumed per CPU
//                               strobe-clear access
//                  KBD_LATEST - single register, newest key overwrites
//   KBD_DATA_W   : default width of the CPU-visible kbd word (strobe + code)
//   KBD_DEPTH    : default number of FIFO entries
// -----------------------------------------------------------------------------
package kbd_buffer_pkg;

  typedef enum logic {
    KBD_FIFO   = 1'b0,
    KBD_LATEST = 1'b1
  } kbd_mode_e;

  localparam int KBD_DATA_W = 8;
  localparam int KBD_DEPTH  = 8;

endpackage : kbd_buffer_pkg

// File: rtl/kbd_fifo_core.sv
// -----------------------------------------------------------------------------
// kbd_fifo_core
//   Storage array, pointers and occupancy counter for the type-ahead queue.
//   The head entry and the non-empty flag are registered so that everything
//   the CPU sees comes straight from flops.
//
//   Parameters
//     CODE_W   : width of one stored key code
//     DEPTH    : number of entries, power of two and >= 2
//
//   Ports
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset
//     push     in   write request for wdata
//     wdata    in   key code to enqueue
//     pop      in   single-cycle dequeue request
//     head     out  oldest entry; holds the last popped code when empty
//     nonempty out  queue holds at least one entry
//     level    out  number of queued entries (0..DEPTH)
//     drop     out  push arrived while full with no pop to make room
// -----------------------------------------------------------------------------
module kbd_fifo_core #(
  parameter int CODE_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CODE_W-1:0]        wdata,
  input  logic                     pop,
  output logic [CODE_W-1:0]        head,
  output logic                     nonempty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Refuse to elaborate with a depth the pointer arithmetic cannot wrap.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kbd_fifo_core: DEPTH must be a power of two and at least 2");
  end

  logic [CODE_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic [CODE_W-1:0] head_q;
  logic [CODE_W-1:0] head_nxt;
  logic              nonempty_q;

  logic full;
  logic pop_en;
  logic wr_en;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    full       = (count_q == CNT_W'(DEPTH));
    pop_en     = pop && (count_q != '0);
    // A full queue still accepts a key when a pop frees the head slot.
    wr_en      = push && (!full || pop_en);
    drop       = push && !wr_en;
    rd_ptr_nxt = pop_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_nxt = count_q;
    case ({wr_en, pop_en})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase

    // Precompute the next head. When the slot about to become the head is the
    // one being written this cycle (push into empty, or push+pop at level 1),
    // the array still holds stale data, so forward wdata instead. When the
    // queue drains, the previous head is kept on display.
    head_nxt = head_q;
    if (count_nxt != '0) begin
      if (wr_en && (rd_ptr_nxt == wr_ptr_q)) begin
        head_nxt = wdata;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers and counter define
  // which entries are valid, and a resettable array would cost a flop reset
  // per bit for nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      nonempty_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q   <= rd_ptr_nxt;
      count_q    <= count_nxt;
      head_q     <= head_nxt;
      nonempty_q <= (count_nxt != '0);
    end
  end

  assign head     = head_q;
  assign nonempty = nonempty_q;
  assign level    = count_q;

endmodule : kbd_fifo_core

// File: rtl/kbd_buffer.sv
// -----------------------------------------------------------------------------
// kbd_buffer
//   Keyboard type-ahead buffer sitting between ps2ctrlr and address_decode.
//   Decoded keys are queued; the CPU sees the oldest key with the strobe bit
//   set, and each rising edge of kbd_clr (a CPU strobe-clear access) advances
//   to the next key. MODE = KBD_LATEST gives the classic single latch where
//   the newest key overwrites the old one.
//
//   Build option: define KBD_BUFFER_STATUS_EN to enable the level and
//   overflow outputs. Without it both read as 0 and ovf_clr is ignored; keys
//   arriving at a full queue are still dropped.
//
//   Parameters
//     DATA_W    : width of kbd; bit DATA_W-1 is the strobe
//     DEPTH     : FIFO entries (power of two, >= 2); unused in KBD_LATEST
//     MODE      : KBD_FIFO or KBD_LATEST
//
//   Ports
//     clock_50  in   system clock
//     res       in   asynchronous active-low reset
//     key_data  in   key code from ps2ctrlr
//     key_valid in   one-cycle push pulse qualifying key_data
//     kbd_clr   in   high during a CPU access to the strobe-clear address
//     ovf_clr   in   one-cycle pulse clearing overflow
//     kbd       out  {kbd_strb, head key code}
//     kbd_strb  out  buffer is non-empty
//     level     out  occupancy
//     overflow  out  sticky lost-key flag
// -----------------------------------------------------------------------------
module kbd_buffer
  import kbd_buffer_pkg::*;
#(
  parameter int        DATA_W = KBD_DATA_W,
  parameter int        DEPTH  = KBD_DEPTH,
  parameter kbd_mode_e MODE   = KBD_FIFO
) (
  input  logic                   clock_50,
  input  logic                   res,
  input  logic [DATA_W-2:0]      key_data,
  input  logic                   key_valid,
  input  logic                   kbd_clr,
  input  logic                   ovf_clr,
  output logic [DATA_W-1:0]      kbd,
  output logic                   kbd_strb,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int CODE_W = DATA_W - 1;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clr_q;
  logic              pop;
  logic [CODE_W-1:0] head;
  logic              nonempty;
  logic [LVL_W-1:0]  occ;
  logic              ovf_event;

  // kbd_clr may stay high for the whole CPU access; only its rising edge
  // counts as a pop.
  always_ff @(posedge clock_50 or negedge res) begin
    if (!res) begin
      clr_q <= 1'b0;
    end else begin
      clr_q <= kbd_clr;
    end
  end

  assign pop = kbd_clr && !clr_q;

  if (MODE == KBD_FIFO) begin : g_fifo

    kbd_fifo_core #(
      .CODE_W (CODE_W),
      .DEPTH  (DEPTH)
    ) u_core (
      .clk      (clock_50),
      .rst_n    (res),
      .push     (key_valid),
      .wdata    (key_data),
      .pop      (pop),
      .head     (head),
      .nonempty (nonempty),
      .level    (occ),
      .drop     (ovf_event)
    );

  end else begin : g_latest

    logic [CODE_W-1:0] code_q;
    logic              strb_q;

    // Push has priority over pop so a key arriving during the clear access
    // is not lost.
    always_ff @(posedge clock_50 or negedge res) begin
      if (!res) begin
        code_q <= '0;
        strb_q <= 1'b0;
      end else if (key_valid) begin
        code_q <= key_data;
        strb_q <= 1'b1;
      end else if (pop) begin
        strb_q <= 1'b0;
      end
    end

    assign head      = code_q;
    assign nonempty  = strb_q;
    assign occ       = LVL_W'(strb_q);
    // Overwriting a key the CPU has not yet cleared loses it.
    assign ovf_event = key_valid && strb_q;

  end

`ifdef KBD_BUFFER_STATUS_EN

  logic ovf_q;

  // A new loss in the same cycle as ovf_clr wins, so no event goes unseen.
  always_ff @(posedge clock_50 or negedge res) begin
    if (!res) begin
      ovf_q <= 1'b0;
    end else if (ovf_event) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
  assign level    = occ;

`else

  // Status outputs are tied off; the occupancy and loss signals feed nothing
  // and are trimmed away by synthesis.
  logic unused_status;
  assign unused_status = ^{ovf_clr, ovf_event, occ};

  assign overflow = 1'b0;
  assign level    = '0;

`endif

  assign kbd      = {nonempty, head};
  assign kbd_strb = nonempty;

endmodule : kbd_buffer

// File: tb/tb_kbd_buffer.sv
// -----------------------------------------------------------------------------
// tb_kbd_buffer
//   Directed bench for kbd_buffer. One instance runs in KBD_FIFO mode and one
//   in KBD_LATEST mode. Inputs change on the falling edge; outputs are sampled
//   on the falling edge after the rising edge that acted on them. Expected
//   level/overflow values follow whether KBD_BUFFER_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_kbd_buffer;
  import kbd_buffer_pkg::*;

`ifdef KBD_BUFFER_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;

  logic [6:0] f_key_data  = '0;
  logic       f_key_valid = 1'b0;
  logic       f_kbd_clr   = 1'b0;
  logic       f_ovf_clr   = 1'b0;
  logic [7:0] f_kbd;
  logic       f_strb;
  logic [3:0] f_level;
  logic       f_ovf;

  logic [6:0] l_key_data  = '0;
  logic       l_key_valid = 1'b0;
  logic       l_kbd_clr   = 1'b0;
  logic       l_ovf_clr   = 1'b0;
  logic [7:0] l_kbd;
  logic       l_strb;
  logic [3:0] l_level;
  logic       l_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kbd_buffer #(.DATA_W(8), .DEPTH(8), .MODE(KBD_FIFO)) dut_fifo (
    .clock_50  (clk),
    .res       (res),
    .key_data  (f_key_data),
    .key_valid (f_key_valid),
    .kbd_clr   (f_kbd_clr),
    .ovf_clr   (f_ovf_clr),
    .kbd       (f_kbd),
    .kbd_strb  (f_strb),
    .level     (f_level),
    .overflow  (f_ovf)
  );

  kbd_buffer #(.DATA_W(8), .DEPTH(8), .MODE(KBD_LATEST)) dut_latest (
    .clock_50  (clk),
    .res       (res),
    .key_data  (l_key_data),
    .key_valid (l_key_valid),
    .kbd_clr   (l_kbd_clr),
    .ovf_clr   (l_ovf_clr),
    .kbd       (l_kbd),
    .kbd_strb  (l_strb),
    .level     (l_level),
    .overflow  (l_ovf)
  );

  // Expected status values when the status outputs are compiled out.
  function automatic logic [3:0] lvl(input int n);
    return STATUS ? 4'(n) : 4'd0;
  endfunction

  function automatic logic ovf(input logic v);
    return STATUS ? v : 1'b0;
  endfunction

  task automatic f_push(input logic [6:0] d);
    @(negedge clk);
    f_key_data  = d;
    f_key_valid = 1'b1;
    @(negedge clk);
    f_key_valid = 1'b0;
  endtask

  task automatic f_pop();
    @(negedge clk);
    f_kbd_clr = 1'b1;
    @(negedge clk);
    f_kbd_clr = 1'b0;
  endtask

  task automatic l_push(input logic [6:0] d);
    @(negedge clk);
    l_key_data  = d;
    l_key_valid = 1'b1;
    @(negedge clk);
    l_key_valid = 1'b0;
  endtask

  task automatic l_pop();
    @(negedge clk);
    l_kbd_clr = 1'b1;
    @(negedge clk);
    l_kbd_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 res = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (f_kbd !== 8'h00) $display("FAIL reset_f_kbd: got %h want 00", f_kbd); else n_pass++;
    n_checks++; if (f_strb !== 1'b0) $display("FAIL reset_f_strb: got %b want 0", f_strb); else n_pass++;
    n_checks++; if (f_level !== 4'd0) $display("FAIL reset_f_level: got %0d want 0", f_level); else n_pass++;
    n_checks++; if (f_ovf !== 1'b0) $display("FAIL reset_f_ovf: got %b want 0", f_ovf); else n_pass++;
    n_checks++; if (l_kbd !== 8'h00) $display("FAIL reset_l_kbd: got %h want 00", l_kbd); else n_pass++;
    n_checks++; if (l_strb !== 1'b0) $display("FAIL reset_l_strb: got %b want 0", l_strb); else n_pass++;
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_key();
    f_push(7'h41);
    n_checks++; if (f_kbd !== 8'hC1) $display("FAIL single_kbd: got %h want C1", f_kbd); else n_pass++;
    n_checks++; if (f_strb !== 1'b1) $display("FAIL single_strb: got %b want 1", f_strb); else n_pass++;
    n_checks++; if (f_level !== lvl(1)) $display("FAIL single_level: got %0d want %0d", f_level, lvl(1)); else n_pass++;
    // Hold kbd_clr for 20 cycles: exactly one pop.
    @(negedge clk);
    f_kbd_clr = 1'b1;
    repeat (20) @(negedge clk);
    f_kbd_clr = 1'b0;
    n_checks++; if (f_kbd !== 8'h41) $display("FAIL single_pop_kbd: got %h want 41", f_kbd); else n_pass++;
    n_checks++; if (f_strb !== 1'b0) $display("FAIL single_pop_strb: got %b want 0", f_strb); else n_pass++;
    n_checks++; if (f_level !== 4'd0) $display("FAIL single_pop_level: got %0d want 0", f_level); else n_pass++;
    // Two keys queued, long clear access: only the first is consumed.
    f_push(7'h61);
    f_push(7'h62);
    n_checks++; if (f_level !== lvl(2)) $display("FAIL hold_level2: got %0d want %0d", f_level, lvl(2)); else n_pass++;
    @(negedge clk);
    f_kbd_clr = 1'b1;
    repeat (20) @(negedge clk);
    f_kbd_clr = 1'b0;
    n_checks++; if (f_kbd !== 8'hE2) $display("FAIL hold_one_pop_kbd: got %h want E2", f_kbd); else n_pass++;
    n_checks++; if (f_level !== lvl(1)) $display("FAIL hold_one_pop_level: got %0d want %0d", f_level, lvl(1)); else n_pass++;
    f_pop();
    n_checks++; if (f_kbd !== 8'h62) $display("FAIL hold_drain_kbd: got %h want 62", f_kbd); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp;
    // 0x30..0x38 on nine consecutive cycles; the ninth finds the queue full.
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      f_key_data  = 7'(8'h30 + i);
      f_key_valid = 1'b1;
      @(negedge clk);
    end
    f_key_valid = 1'b0;
    n_checks++; if (f_level !== lvl(8)) $display("FAIL fill_level: got %0d want %0d", f_level, lvl(8)); else n_pass++;
    n_checks++; if (f_ovf !== ovf(1'b1)) $display("FAIL fill_ovf: got %b want %b", f_ovf, ovf(1'b1)); else n_pass++;
    n_checks++; if (f_kbd !== 8'hB0) $display("FAIL fill_head: got %h want B0", f_kbd); else n_pass++;
    // Plain clear.
    @(negedge clk);
    f_ovf_clr = 1'b1;
    @(negedge clk);
    f_ovf_clr = 1'b0;
    n_checks++; if (f_ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", f_ovf); else n_pass++;
    // Clear coinciding with a new loss: the flag stays set.
    @(negedge clk);
    f_key_data  = 7'h39;
    f_key_valid = 1'b1;
    f_ovf_clr   = 1'b1;
    @(negedge clk);
    f_key_valid = 1'b0;
    f_ovf_clr   = 1'b0;
    n_checks++; if (f_ovf !== ovf(1'b1)) $display("FAIL ovf_clr_vs_event: got %b want %b", f_ovf, ovf(1'b1)); else n_pass++;
    n_checks++; if (f_level !== lvl(8)) $display("FAIL full_drop_level: got %0d want %0d", f_level, lvl(8)); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp = 8'h80 | (8'h30 + 8'(i));
      n_checks++; if (f_kbd !== exp) $display("FAIL fill_order[%0d]: got %h want %h", i, f_kbd, exp); else n_pass++;
      f_pop();
    end
    n_checks++; if (f_kbd !== 8'h37) $display("FAIL fill_empty_kbd: got %h want 37", f_kbd); else n_pass++;
    n_checks++; if (f_level !== 4'd0) $display("FAIL fill_empty_level: got %0d want 0", f_level); else n_pass++;
    @(negedge clk);
    f_ovf_clr = 1'b1;
    @(negedge clk);
    f_ovf_clr = 1'b0;
    n_checks++; if (f_ovf !== 1'b0) $display("FAIL ovf_clr_final: got %b want 0", f_ovf); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      f_key_data  = 7'(8'h20 + i);
      f_key_valid = 1'b1;
      @(negedge clk);
    end
    f_key_valid = 1'b0;
    // Full: push and pop together.
    @(negedge clk);
    f_key_data  = 7'h50;
    f_key_valid = 1'b1;
    f_kbd_clr   = 1'b1;
    @(negedge clk);
    f_key_valid = 1'b0;
    f_kbd_clr   = 1'b0;
    n_checks++; if (f_level !== lvl(8)) $display("FAIL sim_full_level: got %0d want %0d", f_level, lvl(8)); else n_pass++;
    n_checks++; if (f_ovf !== 1'b0) $display("FAIL sim_full_ovf: got %b want 0", f_ovf); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? (8'hA1 + 8'(i)) : 8'hD0;
      n_checks++; if (f_kbd !== exp) $display("FAIL sim_full_order[%0d]: got %h want %h", i, f_kbd, exp); else n_pass++;
      f_pop();
    end
    n_checks++; if (f_strb !== 1'b0) $display("FAIL sim_drained_strb: got %b want 0", f_strb); else n_pass++;
    // Empty: only the push acts.
    @(negedge clk);
    f_key_data  = 7'h50;
    f_key_valid = 1'b1;
    f_kbd_clr   = 1'b1;
    @(negedge clk);
    f_key_valid = 1'b0;
    f_kbd_clr   = 1'b0;
    n_checks++; if (f_level !== lvl(1)) $display("FAIL sim_empty_level: got %0d want %0d", f_level, lvl(1)); else n_pass++;
    n_checks++; if (f_kbd !== 8'hD0) $display("FAIL sim_empty_kbd: got %h want D0", f_kbd); else n_pass++;
    f_pop();
    n_checks++; if (f_strb !== 1'b0) $display("FAIL sim_empty_pop_strb: got %b want 0", f_strb); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 20; i++) begin
      f_push(7'(i));
      exp = 8'h80 | 8'(i);
      n_checks++; if (f_kbd !== exp) $display("FAIL wrap_head[%0d]: got %h want %h", i, f_kbd, exp); else n_pass++;
      f_pop();
    end
    n_checks++; if (f_kbd !== 8'h13) $display("FAIL wrap_end_kbd: got %h want 13", f_kbd); else n_pass++;
  endtask

  task automatic test_latest();
    l_push(7'h41);
    n_checks++; if (l_kbd !== 8'hC1) $display("FAIL latest_first_kbd: got %h want C1", l_kbd); else n_pass++;
    n_checks++; if (l_level !== lvl(1)) $display("FAIL latest_level: got %0d want %0d", l_level, lvl(1)); else n_pass++;
    n_checks++; if (l_ovf !== 1'b0) $display("FAIL latest_first_ovf: got %b want 0", l_ovf); else n_pass++;
    l_push(7'h42);
    n_checks++; if (l_kbd !== 8'hC2) $display("FAIL latest_overwrite_kbd: got %h want C2", l_kbd); else n_pass++;
    n_checks++; if (l_ovf !== ovf(1'b1)) $display("FAIL latest_ovf: got %b want %b", l_ovf, ovf(1'b1)); else n_pass++;
    @(negedge clk);
    l_ovf_clr = 1'b1;
    @(negedge clk);
    l_ovf_clr = 1'b0;
    n_checks++; if (l_ovf !== 1'b0) $display("FAIL latest_ovf_clr: got %b want 0", l_ovf); else n_pass++;
    l_pop();
    n_checks++; if (l_strb !== 1'b0) $display("FAIL latest_pop_strb: got %b want 0", l_strb); else n_pass++;
    n_checks++; if (l_kbd !== 8'h42) $display("FAIL latest_pop_kbd: got %h want 42", l_kbd); else n_pass++;
    // Push and pop together: push wins.
    @(negedge clk);
    l_key_data  = 7'h43;
    l_key_valid = 1'b1;
    l_kbd_clr   = 1'b1;
    @(negedge clk);
    l_key_valid = 1'b0;
    l_kbd_clr   = 1'b0;
    n_checks++; if (l_kbd !== 8'hC3) $display("FAIL latest_sim_kbd: got %h want C3", l_kbd); else n_pass++;
    l_pop();
    n_checks++; if (l_strb !== 1'b0) $display("FAIL latest_sim_pop_strb: got %b want 0", l_strb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      f_key_data  = 7'(8'h70 + i);
      f_key_valid = 1'b1;
      @(negedge clk);
    end
    f_key_valid = 1'b0;
    n_checks++; if (f_level !== lvl(5)) $display("FAIL mid_level5: got %0d want %0d", f_level, lvl(5)); else n_pass++;
    n_checks++; if (f_kbd !== 8'hF0) $display("FAIL mid_head: got %h want F0", f_kbd); else n_pass++;
    l_push(7'h55);
    l_push(7'h56);
    // Assert reset between edges and look before the next edge.
    @(posedge clk);
    #2 res = 1'b0;
    #1;
    n_checks++; if (f_kbd !== 8'h00) $display("FAIL mid_f_kbd: got %h want 00", f_kbd); else n_pass++;
    n_checks++; if (f_strb !== 1'b0) $display("FAIL mid_f_strb: got %b want 0", f_strb); else n_pass++;
    n_checks++; if (f_level !== 4'd0) $display("FAIL mid_f_level: got %0d want 0", f_level); else n_pass++;
    n_checks++; if (l_kbd !== 8'h00) $display("FAIL mid_l_kbd: got %h want 00", l_kbd); else n_pass++;
    n_checks++; if (l_ovf !== 1'b0) $display("FAIL mid_l_ovf: got %b want 0", l_ovf); else n_pass++;
    @(negedge clk);
    res = 1'b1;
    f_push(7'h75);
    n_checks++; if (f_level !== lvl(1)) $display("FAIL mid_after_level: got %0d want %0d", f_level, lvl(1)); else n_pass++;
    n_checks++; if (f_kbd !== 8'hF5) $display("FAIL mid_after_kbd: got %h want F5", f_kbd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_fill_overflow();
    test_simultaneous();
    test_wrap();
    test_latest();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kbd_buffer
